// File: rtl/cpu_boot_ctrl_if.sv
// cpu_boot_ctrl_if: groups the boot controller's loader stream, CPU-side
// memory port, memory-side port and run handshake/status signals.
// slave  = the boot controller itself
// master = the environment (host, loader, CPU core, memory)
interface cpu_boot_ctrl_if #(
  parameter int ADDR_SIZE = 12,
  parameter int WIDTH     = 32
);
  logic                 start;
  logic                 ld_valid;
  logic [WIDTH-1:0]     ld_data;
  logic                 ld_last;
  logic                 ld_ready;
  logic                 cpu_reset;
  logic                 cpu_halt;
  logic                 cpu_mem_rw;
  logic [ADDR_SIZE-1:0] cpu_mem_addr;
  logic [WIDTH-1:0]     cpu_mem_datain;
  logic                 mem_rw;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [WIDTH-1:0]     mem_datain;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [31:0]          cycle_count;

  modport slave (
    input  start, ld_valid, ld_data, ld_last, cpu_halt,
           cpu_mem_rw, cpu_mem_addr, cpu_mem_datain,
    output ld_ready, cpu_reset, mem_rw, mem_addr, mem_datain,
           busy, done, err, cycle_count
  );

  modport master (
    output start, ld_valid, ld_data, ld_last, cpu_halt,
           cpu_mem_rw, cpu_mem_addr, cpu_mem_datain,
    input  ld_ready, cpu_reset, mem_rw, mem_addr, mem_datain,
           busy, done, err, cycle_count
  );
endinterface

// File: rtl/cpu_boot_ctrl.sv
// cpu_boot_ctrl: run sequencer for one CPU program run.
// Streams a program image into memory from address 0 while the CPU is held
// in reset, releases the CPU after RST_CYCLES cycles, passes the CPU memory
// port through while counting execution cycles, and re-freezes the CPU when
// it halts. The memory port is muxed combinationally so loader writes land
// on the same posedge they are accepted.
// Optional feature: define BOOT_WDOG_EN to end a run with err=1 once
// cycle_count reaches MAX_CYCLES without a halt.
module cpu_boot_ctrl #(
  parameter int ADDR_SIZE  = 12,
  parameter int WIDTH      = 32,
  parameter int RST_CYCLES = 2,
  parameter int MAX_CYCLES = 4096
) (
  input  logic           clk,
  input  logic           reset,
  cpu_boot_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_RELEASE = 3'd2,
    S_RUN     = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // Release timer only needs to count 0..RST_CYCLES-1
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0]        REL_LAST = RW'(RST_CYCLES - 1);
  localparam logic [ADDR_SIZE-1:0] ADDR_MAX = {ADDR_SIZE{1'b1}};
  localparam logic [31:0]          WDOG_LIMIT = 32'(MAX_CYCLES);

  state_t               state;
  logic [ADDR_SIZE-1:0] addr;
  logic [RW-1:0]        rel_cnt;
  logic [31:0]          cycles;
  logic                 err_flag;
  logic [31:0]          cycles_inc;

  // Saturating increment: a very long run pins at all-ones instead of wrapping
  assign cycles_inc = (cycles == 32'hFFFF_FFFF) ? cycles : cycles + 32'd1;

`ifdef BOOT_WDOG_EN
  logic wdog_hit;
  assign wdog_hit = (cycles_inc >= WDOG_LIMIT);
`else
  logic [31:0] unused_wdog_limit;
  assign unused_wdog_limit = WDOG_LIMIT;
`endif

  // Sequencer: state, load address, release timer, run counter and sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      addr     <= {ADDR_SIZE{1'b0}};
      rel_cnt  <= {RW{1'b0}};
      cycles   <= 32'd0;
      err_flag <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state    <= S_LOAD;
            addr     <= {ADDR_SIZE{1'b0}};
            cycles   <= 32'd0;
            err_flag <= 1'b0;
          end
        end
        S_LOAD: begin
          if (bus.ld_valid) begin
            addr <= addr + ADDR_SIZE'(1);
            if (bus.ld_last) begin
              state   <= S_RELEASE;
              rel_cnt <= {RW{1'b0}};
            end else if (addr == ADDR_MAX) begin
              // Image overflowed memory: never release the CPU
              state    <= S_DONE;
              err_flag <= 1'b1;
            end
          end
        end
        S_RELEASE: begin
          if (rel_cnt == REL_LAST) begin
            state <= S_RUN;
          end else begin
            rel_cnt <= rel_cnt + RW'(1);
          end
        end
        S_RUN: begin
          if (bus.cpu_halt) begin
            state <= S_DONE;
          end else begin
            cycles <= cycles_inc;
`ifdef BOOT_WDOG_EN
            if (wdog_hit) begin
              state    <= S_DONE;
              err_flag <= 1'b1;
            end
`endif
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Memory port mux, loader handshake and status decode from the current state
  always_comb begin
    bus.ld_ready   = 1'b0;
    bus.cpu_reset  = 1'b1;
    bus.mem_rw     = 1'b0;
    bus.mem_addr   = {ADDR_SIZE{1'b0}};
    bus.mem_datain = {WIDTH{1'b0}};
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    case (state)
      S_LOAD: begin
        bus.ld_ready   = 1'b1;
        bus.mem_rw     = bus.ld_valid;
        bus.mem_addr   = addr;
        bus.mem_datain = bus.ld_data;
        bus.busy       = 1'b1;
      end
      S_RELEASE: begin
        bus.busy = 1'b1;
      end
      S_RUN: begin
        bus.cpu_reset  = 1'b0;
        bus.mem_rw     = bus.cpu_mem_rw;
        bus.mem_addr   = bus.cpu_mem_addr;
        bus.mem_datain = bus.cpu_mem_datain;
        bus.busy       = 1'b1;
      end
      S_DONE: begin
        bus.done = 1'b1;
      end
      default: begin
        bus.busy = 1'b0;
      end
    endcase
  end

  assign bus.err         = err_flag;
  assign bus.cycle_count = cycles;

endmodule
